fetch_unit: RTL and testbench

//  Program-counter and fetch sequencer that sits directly upstream of the control decoder.
//  - Holds the PC and drives the instruction ROM address.
//  - Splits the returned word into opcode/fcode/operand.
//  - Resolves the decoder's branch controls into the next PC.
//  - Generates DONE: run start handshake, halt detection, cycle count.

---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: holds the PC, slices the fetched word,
// resolves branch controls into the next PC and tracks run/halt with a cycle count.
module fetch_unit #(
  parameter int unsigned        PC_W       = 10,
  parameter int unsigned        INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}},
  parameter int unsigned        CNT_W      = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [PC_W-1:0]    START_ADDR,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [3:0]         opcode,
  output logic               fcode,
  output logic [3:0]         operand,
  input  logic               br_rel_nz,
  input  logic               br_rel_z,
  input  logic               br_abs,
  input  logic               zero,
  input  logic [PC_W-1:0]    rel_offset,
  input  logic [PC_W-1:0]    abs_target,
  output logic               DONE,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q;
  logic              rel_taken;

  // Field slices are unmasked; the decoder gates them with DONE.
  assign opcode      = instr_data[INSTR_W-1 -: 4];
  assign fcode       = instr_data[4];
  assign operand     = instr_data[3:0];
  assign instr_addr  = pc_q;
  assign DONE        = done_q;
  assign cycle_count = cnt_q;

  // Next-state, next-PC and cycle counter
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    rel_taken = (br_rel_z & zero) | (br_rel_nz & ~zero);
    case (state_q)
      S_IDLE, S_HALT: begin
        if (START) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // The halt word parks the PC on itself and ignores any branch controls
        if (instr_data == HALT_INSTR) begin
          state_d = S_HALT;
        end else if (br_abs) begin
          pc_d = abs_target;
        end else if (rel_taken) begin
          pc_d = pc_q + rel_offset;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // DONE is registered from the next state so it tracks the state register exactly
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d != S_RUN);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected PC/DONE values are queued as
// stimulus is driven and compared after each clock edge.
module tb_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [9:0]  START_ADDR;
  logic [9:0]  instr_addr;
  logic [8:0]  instr_data;
  logic [3:0]  opcode;
  logic        fcode;
  logic [3:0]  operand;
  logic        br_rel_nz, br_rel_z, br_abs, zero;
  logic [9:0]  rel_offset, abs_target;
  logic        DONE;
  logic [15:0] cycle_count;

  logic [8:0]  rom [1024];
  logic [9:0]  exp_pc_q [$];
  logic        exp_done_q [$];
  int          checks;
  int          errors;

  typedef struct {
    logic       ab, rz, rnz, z;
    logic [9:0] off, tgt, pc;
  } step_t;

  fetch_unit dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .START_ADDR(START_ADDR),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .opcode(opcode), .fcode(fcode), .operand(operand),
    .br_rel_nz(br_rel_nz), .br_rel_z(br_rel_z), .br_abs(br_abs), .zero(zero),
    .rel_offset(rel_offset), .abs_target(abs_target),
    .DONE(DONE), .cycle_count(cycle_count)
  );

  assign instr_data = rom[instr_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_br();
    br_abs = 1'b0; br_rel_z = 1'b0; br_rel_nz = 1'b0; zero = 1'b0;
    rel_offset = '0; abs_target = '0;
  endtask

  task automatic start_run(input logic [9:0] addr);
    START = 1'b1;
    START_ADDR = addr;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; START_ADDR = '0;
    clear_br();
    #12;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL reset_done: got %b want 1", DONE); end
    checks++; if (instr_addr !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", instr_addr); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cycle_count); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++; if (DONE !== 1'b1 || instr_addr !== 10'd0) begin
      errors++; $display("FAIL idle_hold: done=%b pc=%0d want 1/0", DONE, instr_addr);
    end
  endtask

  task automatic test_start_seq();
    logic [9:0]  pcs [5]  = '{10'd6, 10'd7, 10'd8, 10'd8, 10'd8};
    logic        dns [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] cnts [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd4};
    logic [9:0]  p;
    logic        d;
    start_run(10'd5);
    checks++; if (DONE !== 1'b0 || instr_addr !== 10'd5 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL start: done=%b pc=%0d cnt=%0d want 0/5/0", DONE, instr_addr, cycle_count);
    end
    for (int i = 0; i < 5; i++) begin
      exp_pc_q.push_back(pcs[i]);
      exp_done_q.push_back(dns[i]);
      @(posedge CLK); #1;
      p = exp_pc_q.pop_front();
      d = exp_done_q.pop_front();
      checks++; if (instr_addr !== p || DONE !== d || cycle_count !== cnts[i]) begin
        errors++;
        $display("FAIL seq_halt[%0d]: pc=%0d done=%b cnt=%0d want %0d/%b/%0d",
                 i, instr_addr, DONE, cycle_count, p, d, cnts[i]);
      end
    end
  endtask

  task automatic test_slices();
    rom[8] = 9'b1010_1_0110;
    #1;
    checks++; if (opcode !== 4'hA || fcode !== 1'b1 || operand !== 4'h6) begin
      errors++; $display("FAIL slices: op=%h f=%b opd=%h want a/1/6", opcode, fcode, operand);
    end
    rom[8] = 9'h1FF;
    #1;
  endtask

  task automatic test_rel_branch();
    step_t st [6];
    logic [9:0] p;
    st[0] = '{ab:0, rz:1, rnz:0, z:1, off:10'h3FD, tgt:10'd0,  pc:10'd17};
    st[1] = '{ab:1, rz:0, rnz:0, z:0, off:10'd0,   tgt:10'd20, pc:10'd20};
    st[2] = '{ab:0, rz:1, rnz:0, z:0, off:10'h3FD, tgt:10'd0,  pc:10'd21};
    st[3] = '{ab:1, rz:0, rnz:0, z:0, off:10'd0,   tgt:10'd20, pc:10'd20};
    st[4] = '{ab:0, rz:0, rnz:1, z:0, off:10'd4,   tgt:10'd0,  pc:10'd24};
    st[5] = '{ab:0, rz:0, rnz:1, z:1, off:10'd4,   tgt:10'd0,  pc:10'd25};
    start_run(10'd20);
    for (int i = 0; i < 6; i++) begin
      br_abs = st[i].ab; br_rel_z = st[i].rz; br_rel_nz = st[i].rnz; zero = st[i].z;
      rel_offset = st[i].off; abs_target = st[i].tgt;
      exp_pc_q.push_back(st[i].pc);
      @(posedge CLK); #1;
      p = exp_pc_q.pop_front();
      checks++; if (instr_addr !== p || DONE !== 1'b0) begin
        errors++; $display("FAIL rel_branch[%0d]: pc=%0d done=%b want %0d/0", i, instr_addr, DONE, p);
      end
    end
    clear_br();
  endtask

  task automatic test_priority_wrap();
    step_t st [6];
    logic [9:0] p;
    st[0] = '{ab:1, rz:1, rnz:0, z:1, off:10'd7,   tgt:10'd300,  pc:10'd300};
    st[1] = '{ab:1, rz:0, rnz:0, z:0, off:10'd0,   tgt:10'd1023, pc:10'd1023};
    st[2] = '{ab:0, rz:0, rnz:0, z:0, off:10'd0,   tgt:10'd0,    pc:10'd0};
    st[3] = '{ab:1, rz:0, rnz:0, z:0, off:10'd0,   tgt:10'd2,    pc:10'd2};
    st[4] = '{ab:0, rz:0, rnz:1, z:0, off:10'h3FB, tgt:10'd0,    pc:10'd1021};
    st[5] = '{ab:0, rz:1, rnz:1, z:1, off:10'd1,   tgt:10'd0,    pc:10'd1022};
    for (int i = 0; i < 6; i++) begin
      br_abs = st[i].ab; br_rel_z = st[i].rz; br_rel_nz = st[i].rnz; zero = st[i].z;
      rel_offset = st[i].off; abs_target = st[i].tgt;
      exp_pc_q.push_back(st[i].pc);
      @(posedge CLK); #1;
      p = exp_pc_q.pop_front();
      checks++; if (instr_addr !== p) begin
        errors++; $display("FAIL prio_wrap[%0d]: pc=%0d want %0d", i, instr_addr, p);
      end
    end
    clear_br();
    checks++; if (cycle_count !== 16'd12) begin
      errors++; $display("FAIL run_count: cnt=%0d want 12", cycle_count);
    end
  endtask

  task automatic test_start_in_run_and_restart();
    logic [9:0] p;
    START = 1'b1; START_ADDR = 10'd5;
    exp_pc_q.push_back(10'd1023);
    @(posedge CLK); #1;
    START = 1'b0;
    p = exp_pc_q.pop_front();
    checks++; if (instr_addr !== p || DONE !== 1'b0) begin
      errors++; $display("FAIL start_ignored: pc=%0d done=%b want %0d/0", instr_addr, DONE, p);
    end
    br_abs = 1'b1; abs_target = 10'd8;
    @(posedge CLK); #1;
    clear_br();
    @(posedge CLK); #1;
    checks++; if (DONE !== 1'b1 || instr_addr !== 10'd8 || cycle_count !== 16'd15) begin
      errors++; $display("FAIL halt2: done=%b pc=%0d cnt=%0d want 1/8/15", DONE, instr_addr, cycle_count);
    end
    start_run(10'd0);
    checks++; if (DONE !== 1'b0 || instr_addr !== 10'd0 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL restart: done=%b pc=%0d cnt=%0d want 0/0/0", DONE, instr_addr, cycle_count);
    end
    @(posedge CLK); #1;
    checks++; if (instr_addr !== 10'd1 || cycle_count !== 16'd1) begin
      errors++; $display("FAIL restart_step: pc=%0d cnt=%0d want 1/1", instr_addr, cycle_count);
    end
  endtask

  task automatic test_saturation();
    br_abs = 1'b1; abs_target = 10'd1;
    repeat (65533) @(posedge CLK);
    #1;
    checks++; if (cycle_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre: cnt=%h want fffe", cycle_count);
    end
    @(posedge CLK); #1;
    checks++; if (cycle_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hit: cnt=%h want ffff", cycle_count);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (cycle_count !== 16'hFFFF || instr_addr !== 10'd1 || DONE !== 1'b0) begin
      errors++; $display("FAIL sat_hold: cnt=%h pc=%0d done=%b want ffff/1/0", cycle_count, instr_addr, DONE);
    end
    clear_br();
  endtask

  task automatic test_async_reset();
    logic [9:0] p;
    logic       d;
    #3;
    RST_N = 1'b0;
    #1;
    checks++; if (DONE !== 1'b1 || instr_addr !== 10'd0 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL async_rst: done=%b pc=%0d cnt=%0d want 1/0/0", DONE, instr_addr, cycle_count);
    end
    #2;
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc_q.push_back(10'd0);
      exp_done_q.push_back(1'b1);
      @(posedge CLK); #1;
      p = exp_pc_q.pop_front();
      d = exp_done_q.pop_front();
      checks++; if (instr_addr !== p || DONE !== d) begin
        errors++; $display("FAIL post_rst[%0d]: pc=%0d done=%b want %0d/%b", i, instr_addr, DONE, p, d);
      end
    end
    start_run(10'd5);
    checks++; if (DONE !== 1'b0 || instr_addr !== 10'd5) begin
      errors++; $display("FAIL post_rst_start: done=%b pc=%0d want 0/5", DONE, instr_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[8] = 9'h1FF;
    test_reset();
    test_start_seq();
    test_slices();
    test_rel_branch();
    test_priority_wrap();
    test_start_in_run_and_restart();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
